// File: rtl/barrett_mod_cfg_pipe_if.sv
// Handshake, config and result bundle for the Barrett modular-reduction pipeline.
// The slave modport is the reducer side and the master modport is the client side.
interface barrett_mod_cfg_pipe_if #(
    parameter int unsigned DAT_BITS = 64,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned NUM_MOD  = 4
);
    localparam int unsigned IDX_BITS = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;

    logic                  i_cfg_wr;
    logic [IDX_BITS-1:0]   i_cfg_idx;
    logic [DAT_BITS-1:0]   i_cfg_p;
    logic [DAT_BITS:0]     i_cfg_mu;
    logic                  o_cfg_err;
    logic                  i_val;
    logic                  o_rdy;
    logic [2*DAT_BITS-1:0] i_dat;
    logic [IDX_BITS-1:0]   i_sel;
    logic [CTL_BITS-1:0]   i_ctl;
    logic                  o_val;
    logic                  i_rdy;
    logic [DAT_BITS-1:0]   o_dat;
    logic [CTL_BITS-1:0]   o_ctl;
    logic                  o_err;

    modport slave (
        input  i_cfg_wr, i_cfg_idx, i_cfg_p, i_cfg_mu,
        output o_cfg_err,
        input  i_val, i_dat, i_sel, i_ctl, i_rdy,
        output o_rdy, o_val, o_dat, o_ctl, o_err
    );

    modport master (
        output i_cfg_wr, i_cfg_idx, i_cfg_p, i_cfg_mu,
        input  o_cfg_err,
        output i_val, i_dat, i_sel, i_ctl, i_rdy,
        input  o_rdy, o_val, o_dat, o_ctl, o_err
    );
endinterface

// File: rtl/barrett_mod_cfg_pipe.sv
// Four-stage Barrett reduction x mod P with a software-loaded modulus table.
// Each transaction captures its own P/mu in S1, so later table writes never reach it.
module barrett_mod_cfg_pipe #(
    parameter int unsigned DAT_BITS = 64,
    parameter int unsigned CTL_BITS = 8,
    parameter int unsigned NUM_MOD  = 4
) (
    input logic                   i_clk,
    input logic                   i_rst_n,
    barrett_mod_cfg_pipe_if.slave bus
);
    localparam int unsigned K        = DAT_BITS;
    localparam int unsigned IDX_BITS = (NUM_MOD > 1) ? $clog2(NUM_MOD) : 1;

    logic [K-1:0]       r_tab_p  [NUM_MOD];
    logic [K:0]         r_tab_mu [NUM_MOD];
    logic [NUM_MOD-1:0] r_tab_vld;
    logic [NUM_MOD-1:0] w_wr_hit;
    logic               r_cfg_err;

    logic w_stall;
    logic w_adv;

    logic [K-1:0] w_sel_p;
    logic [K:0]   w_sel_mu;
    logic         w_sel_ok;
    logic [K:0]   w_q1;

    logic                r_s1_vld, r_s1_ok;
    logic [2*K-1:0]      r_s1_x;
    logic [CTL_BITS-1:0] r_s1_ctl;
    logic [K-1:0]        r_s1_p;
    logic [K:0]          r_s1_mu, r_s1_q1;

    logic                r_s2_vld, r_s2_ok;
    logic [2*K-1:0]      r_s2_x;
    logic [CTL_BITS-1:0] r_s2_ctl;
    logic [K-1:0]        r_s2_p;
    logic [K:0]          r_s2_q3;

    logic                r_s3_vld, r_s3_ok;
    logic [CTL_BITS-1:0] r_s3_ctl;
    logic [K-1:0]        r_s3_p;
    logic [K:0]          r_s3_r;

    logic [2*K+1:0] w_prod1;
    logic [K:0]     w_q3;
    logic [2*K:0]   w_prod2;
    logic [K:0]     w_r;
    logic [K:0]     w_r1, w_r2;
    logic [K-1:0]   w_dat;
    logic           w_err;

    // Indices are matched one by one so out-of-range values simply hit nothing.
    always_comb begin
        w_wr_hit = '0;
        w_sel_p  = '0;
        w_sel_mu = '0;
        w_sel_ok = 1'b0;
        for (int i = 0; i < NUM_MOD; i++) begin
            if (bus.i_cfg_wr && bus.i_cfg_p[K-1] && (bus.i_cfg_idx == IDX_BITS'(i))) begin
                w_wr_hit[i] = 1'b1;
            end
            if (bus.i_sel == IDX_BITS'(i)) begin
                w_sel_p  = r_tab_p[i];
                w_sel_mu = r_tab_mu[i];
                w_sel_ok = r_tab_vld[i];
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tab_vld <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_tab_vld <= r_tab_vld | w_wr_hit;
            r_cfg_err <= bus.i_cfg_wr && (w_wr_hit == '0);
        end
    end

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < NUM_MOD; i++) begin
            if (w_wr_hit[i]) begin
                r_tab_p[i]  <= bus.i_cfg_p;
                r_tab_mu[i] <= bus.i_cfg_mu;
            end
        end
    end

    assign bus.o_cfg_err = r_cfg_err;

    // Bubbles are held too: the whole pipe freezes on a stall, no collapsing.
    assign w_stall   = bus.o_val && !bus.i_rdy;
    assign w_adv     = !w_stall;
    assign bus.o_rdy = w_adv;

    assign w_q1    = (K+1)'(bus.i_dat >> (K-1));
    assign w_prod1 = (2*K+2)'(r_s1_q1) * (2*K+2)'(r_s1_mu);
    assign w_q3    = (K+1)'(w_prod1 >> (K+1));
    assign w_prod2 = (2*K+1)'(r_s2_q3) * (2*K+1)'(r_s2_p);
    assign w_r     = (K+1)'((2*K+1)'(r_s2_x) - w_prod2);

    always_comb begin
        w_r1  = (r_s3_r >= {1'b0, r_s3_p}) ? r_s3_r - {1'b0, r_s3_p} : r_s3_r;
        w_r2  = (w_r1 >= {1'b0, r_s3_p}) ? w_r1 - {1'b0, r_s3_p} : w_r1;
        w_dat = r_s3_ok ? w_r2[K-1:0] : '0;
        w_err = !r_s3_ok || (w_r2 >= {1'b0, r_s3_p});
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_vld  <= 1'b0;
            r_s2_vld  <= 1'b0;
            r_s3_vld  <= 1'b0;
            bus.o_val <= 1'b0;
            bus.o_err <= 1'b0;
            bus.o_dat <= '0;
            bus.o_ctl <= '0;
        end else if (w_adv) begin
            r_s1_vld  <= bus.i_val;
            r_s2_vld  <= r_s1_vld;
            r_s3_vld  <= r_s2_vld;
            bus.o_val <= r_s3_vld;
            bus.o_err <= r_s3_vld && w_err;
            if (r_s3_vld) begin
                bus.o_dat <= w_dat;
                bus.o_ctl <= r_s3_ctl;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_adv) begin
            if (bus.i_val) begin
                r_s1_x   <= bus.i_dat;
                r_s1_ctl <= bus.i_ctl;
                r_s1_p   <= w_sel_p;
                r_s1_mu  <= w_sel_mu;
                r_s1_ok  <= w_sel_ok;
                r_s1_q1  <= w_q1;
            end
            if (r_s1_vld) begin
                r_s2_x   <= r_s1_x;
                r_s2_ctl <= r_s1_ctl;
                r_s2_p   <= r_s1_p;
                r_s2_ok  <= r_s1_ok;
                r_s2_q3  <= w_q3;
            end
            if (r_s2_vld) begin
                r_s3_ctl <= r_s2_ctl;
                r_s3_p   <= r_s2_p;
                r_s3_ok  <= r_s2_ok;
                r_s3_r   <= w_r;
            end
        end
    end
endmodule

// File: doc/barrett_mod_cfg_pipe.md
BARRETT_MOD_CFG_PIPE -- requirements
Module: barrett_mod_cfg_pipe

Interface
REQ-001 The parameter DAT_BITS SHALL default to 64 and SHALL set the modulus width K = DAT_BITS.
REQ-002 The parameter CTL_BITS SHALL default to 8 and SHALL set the width of the sideband control field.
REQ-003 The parameter NUM_MOD SHALL default to 4 and SHALL set the number of modulus table entries; IDX_BITS = max(1, $clog2(NUM_MOD)).
REQ-004 The block SHALL use one clock, and its reset SHALL be asynchronous and active-low.
REQ-005 i_clk  in  1  clock.
REQ-006 i_rst_n  in  1  asynchronous active-low reset.
REQ-007 i_cfg_wr  in  1  table write strobe.
REQ-008 i_cfg_idx  in  IDX_BITS  table entry to write.
REQ-009 i_cfg_p  in  DAT_BITS  modulus P.
REQ-010 i_cfg_mu  in  DAT_BITS+1  mu = floor(2^(2K)/P), precomputed by software.
REQ-011 o_cfg_err  out  1  one-cycle pulse on a rejected write.
REQ-012 i_val  in  1  input valid.
REQ-013 o_rdy  out  1  input ready.
REQ-014 i_dat  in  2*DAT_BITS  operand x.
REQ-015 i_sel  in  IDX_BITS  table entry to use.
REQ-016 i_ctl  in  CTL_BITS  sideband control, passed through unchanged.
REQ-017 o_val  out  1  result valid.
REQ-018 i_rdy  in  1  downstream ready.
REQ-019 o_dat  out  DAT_BITS  x mod P.
REQ-020 o_ctl  out  CTL_BITS  i_ctl of the same transaction.
REQ-021 o_err  out  1  per-result error flag, qualified by o_val.

Function
REQ-022 A table write SHALL be accepted only if i_cfg_p[DAT_BITS-1]==1 and i_cfg_idx<NUM_MOD; an accepted write SHALL set the entry's valid bit and take effect on the next cycle.
REQ-023 A rejected write SHALL leave the table unchanged and SHALL pulse o_cfg_err high for exactly one cycle.
REQ-024 Input handshake: a transfer SHALL occur when i_val&&o_rdy; output handshake: a transfer SHALL occur when o_val&&i_rdy.
REQ-025 Stall SHALL be defined as o_val&&!i_rdy; all pipeline stages SHALL hold while stalled, and o_rdy SHALL equal !stall.
REQ-026 Pipeline stages SHALL operate as follows:
 - S1: register x, ctl, and the selected P, mu and entry valid bit; compute q1 = x>>(K-1).
 - S2: q3 = (q1*mu)>>(K+1).
 - S3: r = (x - q3*P) mod 2^(K+1).
 - S4: correction, output register.
REQ-027 Latency from input accept to o_val SHALL be exactly 4 cycles when no stall occurs.
REQ-028 Throughput SHALL be one transaction per cycle.
REQ-029 Pipeline bubbles SHALL propagate as invalid stages and SHALL NOT be collapsed.
REQ-030 S4 correction SHALL compute r1 = (r>=P) ? r-P : r and then o_dat = (r1>=P) ? r1-P : r1.
REQ-031 o_err SHALL be set if, after both subtractions, the value is still >=P (out-of-range x); o_dat is then the truncated value.
REQ-032 A transaction whose selected entry is invalid, or whose i_sel>=NUM_MOD, SHALL output o_dat=0 and o_err=1.
REQ-033 P and mu SHALL be captured per transaction in S1, so a later table write SHALL NOT affect in-flight transactions.
REQ-034 If a write and an input accept hit the same index in the same cycle, the transaction SHALL use the old entry.
REQ-035 All arithmetic SHALL be unsigned, and intermediate products SHALL be full width (q1*mu: 2K+2 bits; q3*P: 2K+1 bits) before truncation.
REQ-036 Every output register SHALL reach its next value only through REQ-024 to REQ-034, with no other side effects.

Reset
REQ-037 Asserting i_rst_n low SHALL immediately clear o_val, o_err, o_cfg_err, every stage valid bit and every table valid bit.
REQ-038 Reset SHALL drive o_dat and o_ctl to 0.
REQ-039 o_rdy SHALL be 1 during and after reset.
REQ-040 Reset asserted mid-operation SHALL discard all in-flight transactions, and no o_val SHALL follow the release of reset until a new input is accepted.
REQ-041 Reset release SHALL be synchronised to i_clk externally, and the first input SHALL be accepted on the first edge after release.

Verification
REQ-042 With DAT_BITS=8, write idx0 P=251 mu=261, then send x=1000 -> o_dat=247, o_err=0, exactly 4 cycles after accept.
REQ-043 Send x=62500 (249*251+1) to idx0 -> o_dat=1; back-to-back x=0, 250, 251 -> o_dat 0, 250, 0 on consecutive cycles.
REQ-044 Write idx1 P=0x7F -> o_cfg_err pulses 1 cycle and the table is unchanged; then send x=5 with i_sel=1 -> o_dat=0, o_err=1.
REQ-045 Write idx1 P=241 mu=271 in the same cycle as accepting x=1000 with i_sel=1 (previously P=251) -> o_dat=247; the next x=1000 -> o_dat=36.
REQ-046 Hold i_rdy=0 for 10 cycles with 6 inputs offered -> o_rdy=0 while o_val&&!i_rdy, and all results arrive in order and unchanged with matching o_ctl.
REQ-047 Pull i_rst_n low with 3 transactions in flight -> o_val=0 immediately, and no stale outputs appear after release.
